sram_ctrl: RTL

Bus responder that serves word transactions issued by the RISC5 CPU bus master (bus_stb/bus_we/bus_addr/data/bus_ack) from an external asynchronous 16-bit SRAM. Each 32-bit bus word takes two SRAM halfword accesses: low half first, then high half. The access length is set by a wait-state parameter. Each transaction is closed with a one-cycle bus_ack. The block sits between the CPU bus and the board pads; the data-bus tristate lives in the top level.

---
 rtl/sram_ctrl_pkg.sv | 15 +
 rtl/sram_ctrl.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/sram_ctrl_pkg.sv
// Shared constants for the SRAM bus responder: FSM state encodings and
// halfword-select values.
package sram_ctrl_pkg;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LO_ACC = 3'd1;
  localparam logic [2:0] S_LO_GAP = 3'd2;
  localparam logic [2:0] S_HI_ACC = 3'd3;
  localparam logic [2:0] S_HI_GAP = 3'd4;
  localparam logic [2:0] S_ACK    = 3'd5;

  localparam logic LO = 1'b0;
  localparam logic HI = 1'b1;

endpackage

// File: rtl/sram_ctrl.sv
// Serves 32-bit bus words from a 16-bit asynchronous SRAM as two halfword
// accesses (low half at the even address first); all pad outputs are registered.
//
// state    | meaning
// IDLE     | waiting for bus_stb
// LO_ACC   | low-half strobe active for WAIT_CYCLES+1 cycles
// LO_GAP   | strobes released, address/data held
// HI_ACC   | high-half strobe active for WAIT_CYCLES+1 cycles
// HI_GAP   | strobes released, address/data held
// ACK      | chip deselected, bus_ack high for one cycle
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        bus_stb,
  input  logic        bus_we,
  input  logic [23:2] bus_addr,
  input  logic [31:0] bus_din,
  output logic [31:0] bus_dout,
  output logic        bus_ack,
  output logic [20:0] sram_addr,
  output logic [15:0] sram_dq_out,
  input  logic [15:0] sram_dq_in,
  output logic        sram_dq_oe,
  output logic        sram_ce_n,
  output logic        sram_oe_n,
  output logic        sram_we_n
);

  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

  logic [2:0]  state_q, state_d;
  logic [3:0]  wait_q, wait_d;
  logic        we_q, we_d;
  logic [19:0] addr_q, addr_d;
  logic [31:0] din_q, din_d;
  logic [31:0] dout_q, dout_d;
  logic        ack_q, ack_d;
  logic [20:0] sa_q, sa_d;
  logic [15:0] dqo_q, dqo_d;
  logic        dq_oe_q, dq_oe_d;
  logic        ce_n_q, ce_n_d;
  logic        oe_n_q, oe_n_d;
  logic        we_n_q, we_n_d;

  // The upper word-address bits lie outside the SRAM and are dropped.
  logic unused_addr_hi;
  assign unused_addr_hi = ^bus_addr[23:22];

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    we_d    = we_q;
    addr_d  = addr_q;
    din_d   = din_q;
    dout_d  = dout_q;
    ack_d   = 1'b0;
    sa_d    = sa_q;
    dqo_d   = dqo_q;
    dq_oe_d = dq_oe_q;
    ce_n_d  = ce_n_q;
    oe_n_d  = oe_n_q;
    we_n_d  = we_n_q;
    case (state_q)
      S_IDLE: begin
        if (bus_stb) begin
          state_d = S_LO_ACC;
          wait_d  = WAIT_LD;
          we_d    = bus_we;
          addr_d  = bus_addr[21:2];
          din_d   = bus_din;
          sa_d    = {bus_addr[21:2], LO};
          ce_n_d  = 1'b0;
          if (bus_we) begin
            dqo_d   = bus_din[15:0];
            dq_oe_d = 1'b1;
            we_n_d  = 1'b0;
          end else begin
            oe_n_d  = 1'b0;
          end
        end
      end
      S_LO_ACC, S_HI_ACC: begin
        if (wait_q == 4'd0) begin
          state_d = (state_q == S_LO_ACC) ? S_LO_GAP : S_HI_GAP;
          we_n_d  = 1'b1;
          oe_n_d  = 1'b1;
          // Read data is captured on the last edge of the strobe.
          if (!we_q) begin
            if (state_q == S_LO_ACC) dout_d[15:0]  = sram_dq_in;
            else                     dout_d[31:16] = sram_dq_in;
          end
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end
      S_LO_GAP: begin
        state_d = S_HI_ACC;
        wait_d  = WAIT_LD;
        sa_d    = {addr_q, HI};
        if (we_q) begin
          dqo_d  = din_q[31:16];
          we_n_d = 1'b0;
        end else begin
          oe_n_d = 1'b0;
        end
      end
      S_HI_GAP: begin
        state_d = S_ACK;
        ce_n_d  = 1'b1;
        dq_oe_d = 1'b0;
        ack_d   = 1'b1;
      end
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      wait_q  <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= 20'd0;
      din_q   <= 32'd0;
      dout_q  <= 32'd0;
      ack_q   <= 1'b0;
      sa_q    <= 21'd0;
      dqo_q   <= 16'd0;
      dq_oe_q <= 1'b0;
      ce_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      dout_q  <= dout_d;
      ack_q   <= ack_d;
      sa_q    <= sa_d;
      dqo_q   <= dqo_d;
      dq_oe_q <= dq_oe_d;
      ce_n_q  <= ce_n_d;
      oe_n_q  <= oe_n_d;
      we_n_q  <= we_n_d;
    end
  end

  assign bus_dout    = dout_q;
  assign bus_ack     = ack_q;
  assign sram_addr   = sa_q;
  assign sram_dq_out = dqo_q;
  assign sram_dq_oe  = dq_oe_q;
  assign sram_ce_n   = ce_n_q;
  assign sram_oe_n   = oe_n_q;
  assign sram_we_n   = we_n_q;

endmodule
